// File: rtl/reg_read_stage.sv
// Register-read stage: drives RF read selects, tracks in-flight writes per register to
// stall RAW hazards, and issues into a one-entry valid/ready output register.
// Optional REG_READ_WB_FORWARD_EN lets a source being written back this cycle issue with wb_data.
module reg_read_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_rs,
   input  logic [2:0]        in_rt,
   input  logic [2:0]        in_rd,
   input  logic              in_use_rs,
   input  logic              in_use_rt,
   input  logic              in_writes,
   input  logic              in_lbi,
   input  logic              in_link,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   output logic [2:0]        rf_read1_sel,
   output logic [2:0]        rf_read2_sel,
   input  logic [DATA_W-1:0] rf_read1_data,
   input  logic [DATA_W-1:0] rf_read2_data,
   input  logic              wb_en,
   input  logic [2:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [2:0]        out_dest,
   output logic              out_writes,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc,
   output logic              err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]  pend_q [8];
   logic [CNT_W-1:0]  pend_d [8];
   logic [CNT_W+1:0]  sum_v  [8];
   logic              out_valid_q;
   logic [DATA_W-1:0] out_rs_data_q;
   logic [DATA_W-1:0] out_rt_data_q;
   logic [2:0]        out_dest_q;
   logic              out_writes_q;
   logic [DATA_W-1:0] out_imm_q;
   logic [DATA_W-1:0] out_pc_q;
   logic              err_q;

   logic [2:0]        dest;
   logic              fwd_rs, fwd_rt;
   logic              haz_rs, haz_rt, haz_rd, hazard;
   logic              accept, err_set, flush_dec;
   logic [DATA_W-1:0] rs_data, rt_data;

   assign dest = in_link ? 3'd7 : (in_lbi ? in_rs : in_rd);

`ifdef REG_READ_WB_FORWARD_EN
   assign fwd_rs = wb_en & (wb_reg == in_rs) & (pend_q[in_rs] == CNT_W'(1));
   assign fwd_rt = wb_en & (wb_reg == in_rt) & (pend_q[in_rt] == CNT_W'(1));
`else
   logic wb_data_unused;
   assign wb_data_unused = ^wb_data;
   assign fwd_rs = 1'b0;
   assign fwd_rt = 1'b0;
`endif

   assign haz_rs = in_use_rs & (pend_q[in_rs] != '0) & ~fwd_rs;
   assign haz_rt = in_use_rt & (pend_q[in_rt] != '0) & ~fwd_rt;
   assign haz_rd = in_writes & (pend_q[dest] == CNT_MAX);
   assign hazard = haz_rs | haz_rt | haz_rd;

   // Valid/ready: an instruction transfers on any cycle with in_valid & in_ready; the output
   // entry transfers on out_valid & out_ready and holds unchanged while out_valid & ~out_ready.
   assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   assign rs_data   = fwd_rs ? wb_data : rf_read1_data;
   assign rt_data   = fwd_rt ? wb_data : rf_read2_data;
   assign err_set   = wb_en & (pend_q[wb_reg] == '0);
   assign flush_dec = flush & out_valid_q & out_writes_q;

   // A writeback to an idle register is ignored; flush and writeback on one register floor at 0.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sum_v[i]  = {2'b00, pend_q[i]}
                   + (CNT_W+2)'(accept & in_writes & (dest == 3'(i)))
                   - (CNT_W+2)'(wb_en & ~err_set & (wb_reg == 3'(i)))
                   - (CNT_W+2)'(flush_dec & (out_dest_q == 3'(i)));
         pend_d[i] = sum_v[i][CNT_W+1] ? '0 : CNT_W'(sum_v[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) pend_q[i] <= '0;
         out_valid_q   <= 1'b0;
         out_rs_data_q <= '0;
         out_rt_data_q <= '0;
         out_dest_q    <= '0;
         out_writes_q  <= 1'b0;
         out_imm_q     <= '0;
         out_pc_q      <= '0;
         err_q         <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) pend_q[i] <= pend_d[i];
         err_q <= err_q | err_set;
         if (accept) begin
            out_valid_q   <= 1'b1;
            out_rs_data_q <= rs_data;
            out_rt_data_q <= rt_data;
            out_dest_q    <= dest;
            out_writes_q  <= in_writes;
            out_imm_q     <= in_imm;
            out_pc_q      <= in_pc;
         end else if (flush | out_ready) begin
            out_valid_q   <= 1'b0;
         end
      end
   end

   assign rf_read1_sel = in_rs;
   assign rf_read2_sel = in_rt;
   assign out_valid    = out_valid_q;
   assign out_rs_data  = out_rs_data_q;
   assign out_rt_data  = out_rt_data_q;
   assign out_dest     = out_dest_q;
   assign out_writes   = out_writes_q;
   assign out_imm      = out_imm_q;
   assign out_pc       = out_pc_q;
   assign err          = err_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus random traffic against an abstract
// scoreboard model (per-register pending counts, RF array, output entry).
module tb_reg_read_stage;
   localparam int DATA_W = 16;
   localparam int MAXC   = 3;
`ifdef REG_READ_WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, flush, in_valid, in_use_rs, in_use_rt, in_writes, in_lbi, in_link;
   logic [2:0] in_rs, in_rt, in_rd, wb_reg;
   logic [DATA_W-1:0] in_imm, in_pc, wb_data;
   logic wb_en, out_ready;
   wire  in_ready, out_valid, out_writes, err;
   wire  [2:0] rf_read1_sel, rf_read2_sel, out_dest;
   wire  [DATA_W-1:0] out_rs_data, out_rt_data, out_imm, out_pc;
   logic [DATA_W-1:0] rf_read1_data, rf_read2_data;

   // reference model state
   logic [DATA_W-1:0] rf_m [8];
   int                pend_m [8];
   logic              ov_m, ow_m, err_m, acc_last;
   logic [2:0]        od_m;
   logic [DATA_W-1:0] ors_m, ort_m, oimm_m, opc_m;
   int n_vec = 0;
   int n_err = 0;

   assign rf_read1_data = rf_m[rf_read1_sel];
   assign rf_read2_data = rf_m[rf_read2_sel];

   always #5 clk = ~clk;

   reg_read_stage #(.DATA_W(DATA_W), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
      .in_writes(in_writes), .in_lbi(in_lbi), .in_link(in_link), .in_imm(in_imm), .in_pc(in_pc),
      .rf_read1_sel(rf_read1_sel), .rf_read2_sel(rf_read2_sel),
      .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rs_data(out_rs_data),
      .out_rt_data(out_rt_data), .out_dest(out_dest), .out_writes(out_writes),
      .out_imm(out_imm), .out_pc(out_pc), .err(err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic set_idle();
      flush = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
      in_use_rs = 0; in_use_rt = 0; in_writes = 0; in_lbi = 0; in_link = 0;
      in_imm = 0; in_pc = 0; wb_en = 0; wb_reg = 0; wb_data = 0; out_ready = 1;
   endtask

   task automatic set_instr(input int rs, input int rt, input int rd, input bit urs,
                            input bit urt, input bit wr, input bit lbi, input bit lnk);
      in_valid = 1; in_rs = 3'(rs); in_rt = 3'(rt); in_rd = 3'(rd);
      in_use_rs = urs; in_use_rt = urt; in_writes = wr; in_lbi = lbi; in_link = lnk;
      in_imm = 16'($urandom); in_pc = 16'($urandom);
   endtask

   // Called at a negedge with inputs set: checks combinational outputs, advances model
   // across the posedge, then checks registered outputs at the following negedge.
   task automatic step();
      int  dest;
      bit  fr, ft, haz, rdy, acc;
      int  np [8];
      #1;
      dest = in_link ? 7 : (in_lbi ? int'(in_rs) : int'(in_rd));
      fr   = FWD && wb_en && wb_reg == in_rs && pend_m[in_rs] == 1;
      ft   = FWD && wb_en && wb_reg == in_rt && pend_m[in_rt] == 1;
      haz  = (in_use_rs && pend_m[in_rs] != 0 && !fr) || (in_use_rt && pend_m[in_rt] != 0 && !ft)
          || (in_writes && pend_m[dest] == MAXC);
      rdy  = !flush && !haz && (!ov_m || out_ready);
      acc  = in_valid && rdy;
      check_val("in_ready", 32'(in_ready), 32'(rdy));
      check_val("rd1_sel", 32'(rf_read1_sel), 32'(in_rs));
      check_val("rd2_sel", 32'(rf_read2_sel), 32'(in_rt));
      np = pend_m;
      if (acc && in_writes) np[dest]++;
      if (wb_en) begin
         if (pend_m[wb_reg] == 0) err_m = 1'b1;
         else np[wb_reg]--;
      end
      if (flush && ov_m && ow_m && np[od_m] > 0) np[od_m]--;
      @(posedge clk);
      pend_m = np;
      if (wb_en) rf_m[wb_reg] <= wb_data;
      if (acc) begin
         ov_m = 1; ors_m = fr ? wb_data : rf_m[in_rs]; ort_m = ft ? wb_data : rf_m[in_rt];
         od_m = 3'(dest); ow_m = in_writes; oimm_m = in_imm; opc_m = in_pc;
      end else if (flush || out_ready) begin
         ov_m = 0;
      end
      acc_last = acc;
      @(negedge clk);
      check_val("out_valid", 32'(out_valid), 32'(ov_m));
      check_val("out_rs_data", 32'(out_rs_data), 32'(ors_m));
      check_val("out_rt_data", 32'(out_rt_data), 32'(ort_m));
      check_val("out_dest", 32'(out_dest), 32'(od_m));
      check_val("out_writes", 32'(out_writes), 32'(ow_m));
      check_val("out_imm", 32'(out_imm), 32'(oimm_m));
      check_val("out_pc", 32'(out_pc), 32'(opc_m));
      check_val("err", 32'(err), 32'(err_m));
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      #1 check_val("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready2", 32'(in_ready), 32'd0);
      rst = 0;
      for (int i = 0; i < 8; i++) pend_m[i] = 0;
      ov_m = 0; ow_m = 0; err_m = 0; od_m = 0; ors_m = 0; ort_m = 0; oimm_m = 0; opc_m = 0;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", 32'({out_rs_data, out_rt_data}), 32'd0);
      check_val("rst_out_misc", 32'({out_dest, out_writes, out_imm}), 32'd0);
      check_val("rst_out_pc", 32'(out_pc), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
   endtask

   task automatic rand_cycle();
      int q[$];
      set_idle();
      if ($urandom_range(0, 3) != 0)
         set_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 5) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      for (int r = 0; r < 8; r++) if (pend_m[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
         wb_en = 1; wb_reg = 3'(q[$urandom_range(0, q.size() - 1)]); wb_data = 16'($urandom);
      end
      step();
   endtask

   initial begin
      int k;
      rst = 1;
      set_idle();
      for (int i = 0; i < 8; i++) rf_m[i] = 16'($urandom);
      rf_m[1] = 16'h1111;
      rf_m[2] = 16'h2222;
      @(negedge clk);
      do_reset();

      // 1) plain issue with no pending writes
      set_instr(1, 2, 0, 1, 1, 0, 0, 0);
      step();
      check_val("t1_valid", 32'(out_valid), 32'd1);
      check_val("t1_rs", 32'(out_rs_data), 32'h1111);
      check_val("t1_rt", 32'(out_rt_data), 32'h2222);

      // 2) RAW on r3 released by writeback of 0xBEEF
      do_reset();
      set_instr(0, 0, 3, 0, 0, 1, 0, 0);
      step();
      set_instr(3, 0, 0, 1, 0, 0, 0, 0);
      step();
      check_val("t2_stall", 32'(out_valid), 32'd0);
      step();
      wb_en = 1; wb_reg = 3; wb_data = 16'hBEEF;
      k = -1;
      for (int c = 0; c < 4; c++) begin
         step();
         wb_en = 0;
         if (acc_last) begin k = c; break; end
      end
      check_val("t2_latency", 32'(k), FWD ? 32'd0 : 32'd1);
      check_val("t2_data", 32'(out_rs_data), 32'hBEEF);
      in_valid = 0;
      step();

      // 3) destination resolution
      do_reset();
      set_instr(0, 0, 2, 0, 0, 1, 0, 1);
      step();
      check_val("t3_link_dest", 32'(out_dest), 32'd7);
      set_instr(4, 0, 1, 0, 0, 1, 1, 0);
      step();
      check_val("t3_lbi_dest", 32'(out_dest), 32'd4);
      set_instr(7, 0, 0, 1, 0, 0, 0, 0);
      step();
      check_val("t3_pend7_stall", 32'(out_valid), 32'd0);

      // 4) counter saturation on r5
      do_reset();
      for (int c = 0; c < 3; c++) begin
         set_instr(0, 0, 5, 0, 0, 1, 0, 0);
         step();
      end
      step();
      check_val("t4_full_stall", 32'(out_valid), 32'd0);
      wb_en = 1; wb_reg = 5; wb_data = 16'h0505;
      step();
      wb_en = 0;
      step();
      check_val("t4_accept", 32'(out_valid), 32'd1);
      check_val("t4_dest", 32'(out_dest), 32'd5);

      // 5) backpressure then flush of a writing entry
      do_reset();
      set_instr(0, 0, 6, 0, 0, 1, 0, 0);
      step();
      out_ready = 0;
      set_instr(1, 1, 0, 1, 1, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         check_val("t5_hold_dest", 32'(out_dest), 32'd6);
      end
      flush = 1;
      step();
      check_val("t5_flushed", 32'(out_valid), 32'd0);
      flush = 0; out_ready = 1;
      set_instr(6, 6, 0, 1, 1, 0, 0, 0);
      step();
      check_val("t5_r6_free", 32'(out_valid), 32'd1);

      // 6) scoreboard underflow is sticky until reset
      do_reset();
      wb_en = 1; wb_reg = 1; wb_data = 16'h7777;
      step();
      wb_en = 0;
      check_val("t6_err", 32'(err), 32'd1);
      set_instr(1, 0, 0, 1, 0, 0, 0, 0);
      step();
      check_val("t6_r1_free", 32'(out_valid), 32'd1);
      set_idle();
      step();
      check_val("t6_err_sticky", 32'(err), 32'd1);
      do_reset();

      // random traffic
      for (int c = 0; c < 3000; c++) rand_cycle();
      set_idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
